// File: rtl/led_step_ctrl.sv
// -----------------------------------------------------------------------------
// led_step_ctrl
//
// Rate controller that feeds the bouncing-LED shifter. Three raw active-low
// push-buttons (faster, slower, pause) are synchronised and debounced. Their
// press events adjust a saturating speed level and a pause flag. A prescaler
// then emits a one-cycle `step` pulse once per period.
// period = max(1, BASE_DIV >> level).
//
// Parameters:
//   BASE_DIV    - step period in clock cycles at level 0 (slowest)
//   LEVELS      - number of speed levels (2..32)
//   DEBOUNCE    - consecutive stable cycles needed to accept a button change (>= 1)
//   START_LEVEL - speed level loaded at reset (< LEVELS)
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   key_fast_n  in   raw "faster" button, active low, asynchronous
//   key_slow_n  in   raw "slower" button, active low, asynchronous
//   key_pause_n in   raw "pause" button, active low, asynchronous
//   step        out  registered one-cycle shift enable
//   level       out  current speed level (0 = slowest)
//   paused      out  high while stepping is suspended
// -----------------------------------------------------------------------------
module led_step_ctrl #(
  parameter int BASE_DIV    = 50_000_000,
  parameter int LEVELS      = 8,
  parameter int DEBOUNCE    = 500_000,
  parameter int START_LEVEL = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_fast_n,
  input  logic                      key_slow_n,
  input  logic                      key_pause_n,
  output logic                      step,
  output logic [$clog2(LEVELS)-1:0] level,
  output logic                      paused
);

  localparam int LW = $clog2(LEVELS);
  localparam int CW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  localparam int K_FAST  = 0;
  localparam int K_SLOW  = 1;
  localparam int K_PAUSE = 2;

  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE - 1);
  localparam logic [LW-1:0] LV_MAX      = LW'(LEVELS - 1);
  localparam logic [LW-1:0] LV_START    = LW'(START_LEVEL);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } run_state_t;

  // ---------------------------------------------------------------------------
  // Synchroniser, debouncer and press-edge detector, one lane per key.
  // Bit order everywhere: {pause, slow, fast}.
  // ---------------------------------------------------------------------------
  logic [2:0]    keys_raw;
  logic [2:0]    sync_a;
  logic [2:0]    sync_b;
  logic [2:0]    stable;
  logic [2:0]    stable_d;
  logic [2:0]    press;
  logic [DW-1:0] db_cnt [3];

  assign keys_raw = {key_pause_n, key_slow_n, key_fast_n};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a   <= '1;
      sync_b   <= '1;
      stable   <= '1;
      stable_d <= '1;
      press    <= '0;
      // NOTE: db_cnt is a handful of flops, not a RAM, so each element gets
      // an explicit reset; a RAM would normally be left unreset.
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_a   <= keys_raw;
      sync_b   <= sync_a;
      stable_d <= stable;
      // Falling edge of the debounced level is a press; release is ignored.
      press    <= stable_d & ~stable;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          // The DEBOUNCE-th consecutive differing sample: accept the change.
          stable[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Run / pause state machine.
  // ---------------------------------------------------------------------------
  run_state_t state;
  run_state_t state_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (press[K_PAUSE]) begin
      state_next = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  assign paused = (state == ST_PAUSE);

  // ---------------------------------------------------------------------------
  // Speed level. Simultaneous fast and slow presses cancel.
  // ---------------------------------------------------------------------------
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_next;
  logic          level_chg;

  always_comb begin
    level_next = level_q;
    if (press[K_FAST] && !press[K_SLOW] && (level_q != LV_MAX)) begin
      level_next = level_q + LW'(1);
    end else if (press[K_SLOW] && !press[K_FAST] && (level_q != '0)) begin
      level_next = level_q - LW'(1);
    end
  end

  // A saturated press leaves level_next == level_q and so does not restart
  // the period.
  assign level_chg = (level_next != level_q);
  assign level     = level_q;

  // ---------------------------------------------------------------------------
  // Prescaler. The period is derived from the current level; a level change
  // restarts it from zero.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic [31:0]   period;
  logic          cnt_hit;

  always_comb begin
    period = 32'(BASE_DIV) >> level_q;
    if (period == 32'd0) begin
      period = 32'd1;
    end
  end

  assign cnt_hit = (32'(cnt) == (period - 32'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= LV_START;
      cnt     <= '0;
      step    <= 1'b0;
    end else begin
      level_q <= level_next;
      if (level_chg) begin
        cnt  <= '0;
        step <= 1'b0;
      end else if (state == ST_PAUSE) begin
        // cnt holds so counting resumes where it stopped.
        step <= 1'b0;
      end else if (cnt_hit) begin
        cnt  <= '0;
        step <= 1'b1;
      end else begin
        cnt  <= cnt + CW'(1);
        step <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_step_ctrl
//
// Scoreboard bench for led_step_ctrl with BASE_DIV=8, LEVELS=4, DEBOUNCE=4,
// START_LEVEL=0. A reference model advances once per rising edge and queues
// the expected {step, level, paused}. A monitor samples the DUT on the
// falling edge and compares it against the head of that queue. The model
// describes debouncing as "the last DEBOUNCE synced samples all differ from
// the accepted value". It describes the step cadence as "running cycles since
// the last restart, modulo the period".
// -----------------------------------------------------------------------------
module tb_led_step_ctrl;

  localparam int BASE_DIV    = 8;
  localparam int LEVELS      = 4;
  localparam int DEBOUNCE    = 4;
  localparam int START_LEVEL = 0;
  localparam int LW          = $clog2(LEVELS);

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic [2:0]    keys_n = 3'b111;   // {pause, slow, fast}
  logic          step;
  logic          paused;
  logic [LW-1:0] level;

  led_step_ctrl #(
    .BASE_DIV    (BASE_DIV),
    .LEVELS      (LEVELS),
    .DEBOUNCE    (DEBOUNCE),
    .START_LEVEL (START_LEVEL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_fast_n  (keys_n[0]),
    .key_slow_n  (keys_n[1]),
    .key_pause_n (keys_n[2]),
    .step        (step),
    .level       (level),
    .paused      (paused)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          step;
    logic [LW-1:0] level;
    logic          paused;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit [1:0]          m_dly   [3];   // raw samples still crossing the synchroniser
  bit [DEBOUNCE-1:0] m_win   [3];   // most recent synced samples
  bit                m_stable[3];
  bit [1:0]          m_evp   [3];   // press events on their way to the level logic
  int                m_level;
  bit                m_paused;
  int                m_run;         // running cycles since the last restart
  bit                m_step;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_dly[k]    = 2'b11;
      m_win[k]    = '1;
      m_stable[k] = 1'b1;
      m_evp[k]    = 2'b00;
    end
    m_level  = START_LEVEL;
    m_paused = 1'b0;
    m_run    = 0;
    m_step   = 1'b0;
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.step   = m_step;
    o.level  = LW'(m_level);
    o.paused = m_paused;
    return o;
  endfunction

  function automatic void model_edge(input logic [2:0] raw);
    bit apply [3];
    bit synced;
    bit flip;
    int nl;
    int p;
    for (int k = 0; k < 3; k++) begin
      synced   = m_dly[k][1];
      m_dly[k] = {m_dly[k][0], raw[k]};
      m_win[k] = {m_win[k][DEBOUNCE-2:0], synced};
      flip     = (m_win[k] == {DEBOUNCE{~m_stable[k]}});
      apply[k] = m_evp[k][1];
      m_evp[k] = {m_evp[k][0], flip && m_stable[k]};
      if (flip) m_stable[k] = ~m_stable[k];
    end
    nl = m_level;
    if (apply[0] && !apply[1]) nl = (m_level + 1 > LEVELS - 1) ? LEVELS - 1 : m_level + 1;
    if (apply[1] && !apply[0]) nl = (m_level - 1 < 0) ? 0 : m_level - 1;
    p = BASE_DIV >> m_level;
    if (p < 1) p = 1;
    if (nl != m_level) begin
      m_run  = 0;
      m_step = 1'b0;
    end else if (!m_paused) begin
      m_run  = m_run + 1;
      m_step = (m_run % p) == 0;
    end else begin
      m_step = 1'b0;
    end
    if (apply[2]) m_paused = ~m_paused;
    m_level = nl;
  endfunction

  initial begin : model_proc
    model_reset();
    exp_q.push_back(model_obs());
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        // Reset overrides anything still queued; the DUT clears at once.
        model_reset();
        exp_q.delete();
        exp_q.push_back(model_obs());
      end else begin
        cyc = cyc + 1;
        model_edge(keys_n);
        exp_q.push_back(model_obs());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input obs_t act, input obs_t exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got step=%b level=%0d paused=%b, want step=%b level=%0d paused=%b",
               name, act.step, act.level, act.paused, exp.step, exp.level, exp.paused);
    end
  endtask

  initial begin : monitor_proc
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        a.step   = step;
        a.level  = level;
        a.paused = paused;
        check($sformatf("cycle %0d rst=%b", cyc, rst), a, e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    @(negedge clk);
    keys_n = keys_n & ~mask;
    repeat (hold) @(negedge clk);
    keys_n = keys_n | mask;
  endtask

  // Reset asserted between edges, then released on a falling edge.
  task automatic async_reset(input int n);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [2:0] K_FAST  = 3'b001;
  localparam logic [2:0] K_SLOW  = 3'b010;
  localparam logic [2:0] K_PAUSE = 3'b100;

  initial begin : stim_proc
    // 1: reset, then free-running at level 0 (steps after edges 8, 16, 24)
    idle(3);
    rst = 1'b1;
    idle(30);

    // 2: step up through every level, including a saturated press
    press(K_FAST, 12);
    idle(20);
    repeat (3) begin
      press(K_FAST, 10);
      idle(12);
    end

    // 3: short glitches are rejected, then one real slow press
    repeat (6) begin
      press(K_SLOW, 3);
      idle(2);
    end
    press(K_SLOW, 10);
    idle(16);

    // 4: pause mid-period at level 0, then resume
    async_reset(2);
    idle($urandom_range(0, 7));
    press(K_PAUSE, 8);
    idle(20);
    press(K_PAUSE, 8);
    idle(20);

    // 5: simultaneous fast and slow cancel; then reset mid-period at level 2
    press(K_FAST | K_SLOW, 8);
    idle(12);
    press(K_FAST, 8);
    idle(10);
    press(K_FAST, 8);
    idle(8 + $urandom_range(0, 2));
    async_reset(3);
    idle(12);

    // Random phase: arbitrary key combinations, glitches and resets
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        async_reset($urandom_range(1, 3));
      end
      press(3'($urandom_range(1, 7)), $urandom_range(1, 12));
      idle($urandom_range(1, 15));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_step_ctrl.md
# led_step_ctrl

Rate controller that sits directly upstream of the bouncing-LED shifter on the Laboratorio_1 board. It turns three raw active-low push-buttons (faster, slower, pause) into a one-cycle `step` enable pulse. Each `step` advances the shifter by one LED position. The step period is set by a saturating speed level. All button inputs are synchronised and debounced inside the block.

## Interface
- `BASE_DIV`, default 50_000_000: step period in clock cycles at level 0 (slowest).
- `LEVELS`, default 8: number of speed levels. Legal range is 2..32.
- `DEBOUNCE`, default 500_000: consecutive stable cycles required to accept a button change. Must be ≥ 1.
- `START_LEVEL`, default 0: speed level loaded at reset. Must be < `LEVELS`.
- `clk`  in  1: single system clock. Everything is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `key_fast_n`  in  1: raw button, active-low, asynchronous to `clk`.
- `key_slow_n`  in  1: raw button, active-low, asynchronous to `clk`.
- `key_pause_n`  in  1: raw button, active-low, asynchronous to `clk`.
- `step`  out  1: registered one-cycle pulse, the shift enable for the downstream shifter.
- `level`  out  $clog2(LEVELS): current speed level. 0 is slowest.
- `paused`  out  1: high while stepping is suspended.

## Operation
- **Synchroniser**: two flops per key, reset to 1 (released).
- **Debouncer** (one per key):
  - Holds `stable` (reset 1) and a counter of width $clog2(DEBOUNCE+1) (reset 0).
  - If synced value == `stable`: counter clears to 0.
  - Otherwise the counter increments. When it would reach `DEBOUNCE`, `stable` takes the synced value and the counter clears.
- **Press event**: registered pulse, asserted for one cycle after `stable` goes 1→0. Release (0→1) produces no event.
- **Speed level**:
  - Fast event: `level`+1, saturating at `LEVELS`-1.
  - Slow event: `level`-1, saturating at 0.
  - Fast and slow events in the same cycle: `level` unchanged.
- **Pause**: each pause event toggles `paused`. It may coincide with a speed event; both take effect.
- **Period**: period = max(1, `BASE_DIV` >> `level`). Shift amount is unsigned. The prescaler counter `cnt` is $clog2(BASE_DIV) bits wide.
- **Prescaler**:
  - Running and `cnt` == period-1: `step` = 1 next cycle, and `cnt` → 0.
  - Running otherwise: `cnt` +1 and `step` = 0.
  - Paused: `cnt` holds its value and `step` = 0. On resume, counting continues from the held value.
- **Level change**: on any cycle where `level` changes value, `cnt` → 0 and no `step` is issued. A saturated press that leaves `level` unchanged does not clear `cnt`.

## Timing
- **Reset values**: `step`=0, `level`=`START_LEVEL`, `paused`=0, `cnt`=0, all sync/`stable` flops=1, debounce counters=0. Reset takes effect immediately and asynchronously, including mid-period and mid-debounce. No event is generated on reset release.
- **Button latency**: key held low from the edge that first samples it low (edge 1):
  - `stable` flips at edge `DEBOUNCE`+2.
  - Press event is high after edge `DEBOUNCE`+3.
  - `level`/`paused` update at edge `DEBOUNCE`+4.
- **Bounce rejection**: a low glitch shorter than `DEBOUNCE` synced cycles produces no event.
- **Step cadence**:
  - After reset release, while running, the first `step` is high after edge P, where P = the period. Subsequent steps are high every P cycles.
  - When P=1, `step` stays high continuously.
- **After a level change**: the first `step` is high after P_new further edges.

## Test plan
Parameters for all scenarios: `BASE_DIV`=8, `LEVELS`=4, `DEBOUNCE`=4, `START_LEVEL`=0.

1. Assert reset, then release it with keys released. -> `level`=0 and `paused`=0. `step` pulses after edges 8, 16, 24, and is 0 on every other cycle.
2. Hold `key_fast_n` low for 12 cycles. -> `level`=1 at edge 8 and `cnt` clears. Steps follow at period 4. Three more presses give `level`=2 (period 2), then 3 (period 1, `step` held high), then 3 again (saturated, `cnt` not cleared).
3. Glitch `key_slow_n` low for 3 cycles, six times with 2 cycles high between. -> `level` unchanged and no `cnt` clear. Then hold it low for 10 cycles. -> `level` decrements by exactly 1.
4. At `cnt`=5 (level 0), press pause. -> `paused`=1, `step` stays 0, `cnt` frozen. Press pause again. -> `step` appears exactly 8-(frozen `cnt`) edges after the resume update.
5. Debounce fast and slow so their events land in the same cycle. -> `level` unchanged. Then, at level 2 mid-period, assert reset. -> all outputs return to reset values immediately, and `level`=0.
